// File: rtl/seq_detect_sched_pkg.sv
// seq_detect_pkg: shared types and constants for the round-robin pattern-detector scheduler.
package seq_detect_pkg;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        PRIMED  = 2'd2
    } fill_state_t;

    // Wide enough for any PAT_LEN up to 8; the top slices off what it needs.
    localparam logic [7:0] DEF_PATTERN = 8'b0000_0101;

    function automatic int chw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seq_detect_sched_if.sv
// seq_detect_sched_if: request/config/result signals of the scheduler; master drives requests, slave is the block.
interface seq_detect_sched_if
    import seq_detect_pkg::*;
#(
    parameter int NCH     = 4,
    parameter int PAT_LEN = 3
);
    localparam int CW = chw(NCH);

    logic               cfg_load;
    logic [PAT_LEN-1:0] cfg_pattern;
    logic [NCH-1:0]     req_valid;
    logic [NCH-1:0]     req_bit;
    logic [NCH-1:0]     req_ready;
    logic               det_valid;
    logic [CW-1:0]      det_ch;
    logic               det_hit;
    logic               busy;

    modport master (
        output cfg_load, cfg_pattern, req_valid, req_bit,
        input  req_ready, det_valid, det_ch, det_hit, busy
    );

    modport slave (
        input  cfg_load, cfg_pattern, req_valid, req_bit,
        output req_ready, det_valid, det_ch, det_hit, busy
    );

endinterface

// File: rtl/seq_detect_sched_rr_arbiter.sv
// rr_arbiter: one-hot round-robin grant starting after the last accepted channel.
module rr_arbiter
    import seq_detect_pkg::*;
#(
    parameter int NCH = 4,
    localparam int CW = chw(NCH)
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic [NCH-1:0] i_req,
    input  logic           i_block,
    output logic [NCH-1:0] o_grant,
    output logic [CW-1:0]  o_idx
);

    logic [CW-1:0] r_ptr;

    always_comb begin : search
        logic          found;
        logic [CW-1:0] j;
        o_grant = '0;
        o_idx   = '0;
        found   = 1'b0;
        j       = '0;
        for (int k = 0; k < NCH; k++) begin
            j = CW'((int'(r_ptr) + k) % NCH);
            if (!found && !i_block && i_req[j]) begin
                found      = 1'b1;
                o_grant[j] = 1'b1;
                o_idx      = j;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_ptr <= '0;
        else if (|o_grant)
            r_ptr <= (o_idx == CW'(NCH - 1)) ? '0 : o_idx + 1'b1;
    end

endmodule

// File: rtl/seq_detect_sched.sv
// seq_detect_sched: round-robin sharing of one serial pattern detector across NCH bit streams.
// Optional HIT_COUNT_EN adds per-channel saturating hit counters read via cnt_sel/cnt_value.
module seq_detect_sched
    import seq_detect_pkg::*;
#(
    parameter int                 NCH       = 4,
    parameter int                 PAT_LEN   = 3,
    parameter logic [PAT_LEN-1:0] PAT_RESET = DEF_PATTERN[PAT_LEN-1:0]
) (
    input  logic                 clock,
    input  logic                 reset,
    seq_detect_sched_if.slave    bus
`ifdef HIT_COUNT_EN
    ,
    input  logic [chw(NCH)-1:0]  cnt_sel,
    output logic [7:0]           cnt_value
`endif
);

    localparam int CW = chw(NCH);
    localparam int FW = $clog2(PAT_LEN + 1);

    logic [PAT_LEN-1:0] r_pattern;
    logic [PAT_LEN-1:0] r_hist [NCH];
    logic [PAT_LEN-1:0] w_hist_nxt [NCH];
    logic [FW-1:0]      r_fill [NCH];
    logic [FW-1:0]      w_fill_nxt [NCH];
    fill_state_t        r_state [NCH];
    fill_state_t        w_state_nxt [NCH];
    logic [NCH-1:0]     w_grant;
    logic [CW-1:0]      w_idx;
    logic               w_xfer;
    logic               w_hit;
    logic               r_det_valid;
    logic [CW-1:0]      r_det_ch;
    logic               r_det_hit;

    // Reset is folded into the block input so the grant is zero while reset is held.
    rr_arbiter #(.NCH(NCH)) u_arb (
        .i_clk   (clock),
        .i_rst   (reset),
        .i_req   (bus.req_valid),
        .i_block (reset | bus.cfg_load),
        .o_grant (w_grant),
        .o_idx   (w_idx)
    );

    assign w_xfer = |w_grant;

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            w_hist_nxt[i]  = r_hist[i];
            w_fill_nxt[i]  = r_fill[i];
            w_state_nxt[i] = r_state[i];
            if (bus.cfg_load) begin
                w_hist_nxt[i]  = '0;
                w_fill_nxt[i]  = '0;
                w_state_nxt[i] = EMPTY;
            end else if (w_grant[i]) begin
                w_hist_nxt[i]  = {r_hist[i][PAT_LEN-2:0], bus.req_bit[i]};
                w_fill_nxt[i]  = (r_state[i] == PRIMED) ? r_fill[i] : r_fill[i] + 1'b1;
                w_state_nxt[i] = (r_state[i] == PRIMED || r_fill[i] == FW'(PAT_LEN - 1)) ? PRIMED : FILLING;
            end
        end
    end

    assign w_hit = (w_hist_nxt[w_idx] == r_pattern) && (w_state_nxt[w_idx] == PRIMED);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_pattern   <= PAT_RESET;
            r_det_valid <= 1'b0;
            r_det_ch    <= '0;
            r_det_hit   <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                r_hist[i]  <= '0;
                r_fill[i]  <= '0;
                r_state[i] <= EMPTY;
            end
        end else begin
            if (bus.cfg_load)
                r_pattern <= bus.cfg_pattern;
            for (int i = 0; i < NCH; i++) begin
                r_hist[i]  <= w_hist_nxt[i];
                r_fill[i]  <= w_fill_nxt[i];
                r_state[i] <= w_state_nxt[i];
            end
            r_det_valid <= w_xfer;
            if (w_xfer) begin
                r_det_ch  <= w_idx;
                r_det_hit <= w_hit;
            end
        end
    end

`ifdef HIT_COUNT_EN
    logic [7:0] r_cnt [NCH];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NCH; i++)
                r_cnt[i] <= '0;
        end else if (bus.cfg_load) begin
            for (int i = 0; i < NCH; i++)
                r_cnt[i] <= '0;
        end else if (w_xfer && w_hit && r_cnt[w_idx] != 8'hFF) begin
            r_cnt[w_idx] <= r_cnt[w_idx] + 8'd1;
        end
    end

    assign cnt_value = r_cnt[cnt_sel];
`endif

    assign bus.req_ready = w_grant;
    assign bus.det_valid = r_det_valid;
    assign bus.det_ch    = r_det_ch;
    assign bus.det_hit   = r_det_hit;
    assign bus.busy      = |bus.req_valid;

endmodule
